// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared definitions for the FIFO write-port arbiter slice.
//   arb_state_t     : arbiter FSM state (ST_IDLE / ST_LOCKED)
//   DEFAULT_TIMEOUT : default mid-frame watchdog limit in idle cycles
//   clog2()         : index-width helper, never returns less than 1
package fifo_arb_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_t;

  localparam int unsigned DEFAULT_TIMEOUT = 16;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/rr_arb_pick.sv
// rr_arb_pick: combinational round-robin picker.
//   candidates : requesters eligible this cycle
//   rr_last    : index served last; scanning starts at rr_last+1 and wraps
//                modulo N_REQ, so rr_last itself is checked last
//   found      : at least one candidate exists
//   winner     : index of the first candidate in scan order
module rr_arb_pick
  import fifo_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned IDX_W = clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] candidates,
  input  logic [IDX_W-1:0] rr_last,
  output logic             found,
  output logic [IDX_W-1:0] winner
);

  always_comb begin
    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] idx;
    found  = 1'b0;
    winner = '0;
    sum    = '0;
    idx    = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      // one extra bit so rr_last+k cannot overflow before the modulo fold
      sum = {1'b0, rr_last} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(N_REQ)) sum = sum - (IDX_W+1)'(N_REQ);
      idx = sum[IDX_W-1:0];
      if (!found && candidates[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: shares the dual-clock FIFO write port between N_REQ
// write-domain requesters. Frame-granular round-robin; the grant is locked
// until the LAST beat of a frame is written or a watchdog expires.
//   CLK, RST   : write clock, synchronous active-high reset
//   EN_MASK    : per-requester arbitration enable (sampled at arbitration only)
//   REQ_VALID/REQ_DATA/REQ_LAST/REQ_READY : requester beat handshakes
//   W_FULL     : FIFO full flag; W_INC/WR_DATA : FIFO write strobe and data
//   GRANT      : registered one-hot grant; BUSY : grant held
//   TMO_ERR    : one-cycle pulse in the cycle the watchdog releases the port
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned N_REQ      = 2,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned TIMEOUT    = DEFAULT_TIMEOUT
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [N_REQ-1:0]            EN_MASK,
  input  logic [N_REQ-1:0]            REQ_VALID,
  input  logic [N_REQ*DATA_WIDTH-1:0] REQ_DATA,
  input  logic [N_REQ-1:0]            REQ_LAST,
  output logic [N_REQ-1:0]            REQ_READY,
  input  logic                        W_FULL,
  output logic                        W_INC,
  output logic [DATA_WIDTH-1:0]       WR_DATA,
  output logic [N_REQ-1:0]            GRANT,
  output logic                        BUSY,
  output logic                        TMO_ERR
);

  localparam int unsigned      IDX_W    = clog2(N_REQ);
  localparam int unsigned      TMR_W    = clog2(TIMEOUT);
  localparam logic [IDX_W-1:0] RR_RESET = IDX_W'(N_REQ - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  arb_state_t       state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] g_q, g_d;            // index form of grant_q
  logic [IDX_W-1:0] rr_last_q, rr_last_d;
  logic [TMR_W-1:0] timer_q, timer_d;

  logic [N_REQ-1:0] cand;
  logic [IDX_W-1:0] pick_base, pick_winner;
  logic             pick_found;
  logic             accept, idle_cyc, wd_fire, frame_end;

  assign cand = REQ_VALID & EN_MASK;

  // One picker serves both paths: from IDLE it scans after rr_last, at a
  // frame end it scans after the port just released (the new rr_last).
  assign pick_base = (state_q == ST_LOCKED) ? g_q : rr_last_q;

  rr_arb_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .candidates (cand),
    .rr_last    (pick_base),
    .found      (pick_found),
    .winner     (pick_winner)
  );

  // grant_q is all-zero outside LOCKED, so these fall to 0 in IDLE
  assign accept    = (|(grant_q & REQ_VALID)) && !W_FULL;
  assign idle_cyc  = (state_q == ST_LOCKED) && !(|(grant_q & REQ_VALID)) && !W_FULL;
  assign wd_fire   = idle_cyc && (timer_q == TMR_LAST);
  assign frame_end = (accept && (|(grant_q & REQ_LAST))) || wd_fire;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      g_q       <= '0;
      rr_last_q <= RR_RESET;
      timer_q   <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      g_q       <= g_d;
      rr_last_q <= rr_last_d;
      timer_q   <= timer_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    g_d       = g_q;
    rr_last_d = rr_last_q;
    timer_d   = timer_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          state_d              = ST_LOCKED;
          g_d                  = pick_winner;
          grant_d              = '0;
          grant_d[pick_winner] = 1'b1;
          timer_d              = '0;
        end
      end
      ST_LOCKED: begin
        if (accept)        timer_d = '0;
        else if (idle_cyc) timer_d = wd_fire ? '0 : timer_q + TMR_W'(1);
        if (frame_end) begin
          rr_last_d = g_q;
          if (pick_found) begin
            g_d                  = pick_winner;
            grant_d              = '0;
            grant_d[pick_winner] = 1'b1;
          end else begin
            state_d = ST_IDLE;
            grant_d = '0;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_comb begin
    REQ_READY = grant_q & {N_REQ{!W_FULL}};
    W_INC     = accept;
    TMO_ERR   = wd_fire;
    WR_DATA   = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant_q[i]) WR_DATA = WR_DATA | REQ_DATA[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign GRANT = grant_q;
  assign BUSY  = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: self-checking bench for fifo_wr_arbiter (2 ports,
// 8-bit data, TIMEOUT 16). A behavioural model tracks grant owner, last
// served port and stall count; directed scenarios add explicit checks.
module tb_fifo_wr_arbiter;

  localparam int N   = 2;
  localparam int DW  = 8;
  localparam int TMO = 16;
  localparam int VW  = 2*N + DW + 3;

  logic          CLK = 1'b0;
  logic          RST;
  logic [N-1:0]  EN_MASK, REQ_VALID, REQ_LAST, REQ_READY, GRANT;
  logic [N*DW-1:0] REQ_DATA;
  logic [DW-1:0] d0, d1, WR_DATA;
  logic          W_FULL, W_INC, BUSY, TMO_ERR;

  int errors = 0;
  int checks = 0;

  assign REQ_DATA = {d1, d0};

  always #5 CLK = ~CLK;

  fifo_wr_arbiter #(.N_REQ(N), .DATA_WIDTH(DW), .TIMEOUT(TMO)) dut (
    .CLK(CLK), .RST(RST), .EN_MASK(EN_MASK), .REQ_VALID(REQ_VALID),
    .REQ_DATA(REQ_DATA), .REQ_LAST(REQ_LAST), .REQ_READY(REQ_READY),
    .W_FULL(W_FULL), .W_INC(W_INC), .WR_DATA(WR_DATA), .GRANT(GRANT),
    .BUSY(BUSY), .TMO_ERR(TMO_ERR)
  );

  // ---------------- reference model ----------------
  bit m_busy  = 1'b0;
  int m_g     = 0;
  int m_rr    = N - 1;
  int m_timer = 0;

  function automatic bit bitof(input logic [N-1:0] v, input int i);
    logic [N-1:0] t;
    t = v >> i;
    return t[0];
  endfunction

  function automatic int pick(input int base, input logic [N-1:0] c);
    for (int k = 1; k <= N; k++) if (bitof(c, (base + k) % N)) return (base + k) % N;
    return -1;
  endfunction

  task automatic model_step();
    logic [N-1:0] c;
    int w;
    bit rel;
    c = REQ_VALID & EN_MASK;
    if (RST) begin
      m_busy = 0; m_g = 0; m_rr = N - 1; m_timer = 0;
    end else if (!m_busy) begin
      w = pick(m_rr, c);
      if (w >= 0) begin m_busy = 1; m_g = w; m_timer = 0; end
    end else begin
      rel = 0;
      if (!W_FULL && bitof(REQ_VALID, m_g)) begin
        m_timer = 0;
        rel = bitof(REQ_LAST, m_g);
      end else if (!W_FULL) begin
        if (m_timer == TMO - 1) begin rel = 1; m_timer = 0; end
        else m_timer++;
      end
      if (rel) begin
        m_rr = m_g;
        w = pick(m_rr, c);
        if (w >= 0) m_g = w; else m_busy = 0;
      end
    end
  endtask

  initial forever begin
    @(posedge CLK);
    model_step();
  end

  logic [VW-1:0] obs, exp_v;
  assign obs = {REQ_READY, W_INC, WR_DATA, TMO_ERR, GRANT, BUSY};

  always_comb begin
    logic [N-1:0]  gh;
    logic [DW-1:0] dd;
    bit v;
    gh = m_busy ? (N'(1) << m_g) : '0;
    v  = bitof(REQ_VALID, m_g);
    dd = m_busy ? DW'(REQ_DATA >> (m_g * DW)) : '0;
    exp_v = {gh & {N{!W_FULL}}, m_busy && v && !W_FULL, dd,
             m_busy && !v && !W_FULL && (m_timer == TMO - 1), gh, m_busy};
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    RST = 1; REQ_VALID = '0; REQ_LAST = '0; EN_MASK = '1; W_FULL = 0; d0 = '0; d1 = '0;
    @(posedge CLK); #1;
    RST = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    RST = 1; REQ_VALID = 2'b11; REQ_LAST = 2'b11; EN_MASK = 2'b11; W_FULL = 0;
    d0 = 8'h3C; d1 = 8'hC3;
    @(posedge CLK); #1;
    @(negedge CLK);
    checks++;
    if (obs !== '0) begin errors++; $display("FAIL reset_state: got %h want 0", obs); end
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL reset_model: got %h want %h", obs, exp_v); end
    @(posedge CLK); #1;
    RST = 0;
    @(posedge CLK); #1;
    @(negedge CLK);
    checks++;
    if (GRANT !== 2'b01) begin errors++; $display("FAIL reset_first_grant: got %b want 01", GRANT); end
  endtask

  task automatic test_alternate();
    logic [DW-1:0] wlog[$];
    do_reset();
    REQ_VALID = 2'b11; REQ_LAST = 2'b11; EN_MASK = 2'b11; d0 = 8'hA0; d1 = 8'hB1;
    for (int c = 0; c < 9; c++) begin
      @(negedge CLK);
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL alt_model c%0d: got %h want %h", c, obs, exp_v); end
      if (W_INC) wlog.push_back(WR_DATA);
      @(posedge CLK); #1;
    end
    checks++;
    if (wlog.size() != 8) begin errors++; $display("FAIL alt_count: got %0d want 8", wlog.size()); end
    for (int i = 0; i < wlog.size() && i < 8; i++) begin
      checks++;
      if (wlog[i] !== ((i % 2 == 0) ? 8'hA0 : 8'hB1))
        begin errors++; $display("FAIL alt_order[%0d]: got %h want %h", i, wlog[i], (i % 2 == 0) ? 8'hA0 : 8'hB1); end
    end
  endtask

  task automatic test_multibeat();
    logic [DW-1:0] frame [3];
    logic [DW-1:0] want  [4];
    logic [DW-1:0] wlog[$];
    int b;
    bit acc;
    frame[0] = 8'hAA; frame[1] = 8'hBB; frame[2] = 8'hCC;
    want[0] = 8'hAA; want[1] = 8'hBB; want[2] = 8'hCC; want[3] = 8'h11;
    do_reset();
    b = 0; EN_MASK = 2'b11; REQ_VALID = 2'b11; REQ_LAST = 2'b10; d0 = frame[0]; d1 = 8'h11;
    for (int c = 0; c < 7; c++) begin
      @(negedge CLK);
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL mb_model c%0d: got %h want %h", c, obs, exp_v); end
      acc = REQ_READY[0] && REQ_VALID[0];
      if (W_INC) wlog.push_back(WR_DATA);
      @(posedge CLK); #1;
      if (acc) begin
        b++;
        if (b >= 3) REQ_VALID[0] = 1'b0;
        else begin d0 = frame[b]; REQ_LAST[0] = (b == 2); end
      end
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= wlog.size() || wlog[i] !== want[i])
        begin errors++; $display("FAIL mb_seq[%0d]: got %h want %h", i, (i < wlog.size()) ? wlog[i] : 8'hxx, want[i]); end
    end
  endtask

  task automatic test_full();
    int b;
    bit acc;
    do_reset();
    b = 0; EN_MASK = 2'b11; REQ_VALID = 2'b01; REQ_LAST = 2'b00; d0 = 8'h10; d1 = 8'hEE;
    for (int c = 0; c < 12; c++) begin
      W_FULL = (c >= 2 && c < 7);
      @(negedge CLK);
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL full_model c%0d: got %h want %h", c, obs, exp_v); end
      if (c >= 2 && c < 7) begin
        checks++;
        if ({W_INC, REQ_READY, GRANT, TMO_ERR} !== 6'b0_00_01_0)
          begin errors++; $display("FAIL full_hold c%0d: got %b want 000010", c, {W_INC, REQ_READY, GRANT, TMO_ERR}); end
      end
      if (c == 7) begin
        checks++;
        if (W_INC !== 1'b1 || WR_DATA !== 8'h11)
          begin errors++; $display("FAIL full_resume: got inc=%b data=%h want inc=1 data=11", W_INC, WR_DATA); end
      end
      acc = REQ_READY[0] && REQ_VALID[0];
      @(posedge CLK); #1;
      if (acc) begin
        b++;
        if (b >= 4) REQ_VALID[0] = 1'b0;
        else begin d0 = 8'h10 + 8'(b); REQ_LAST[0] = (b == 3); end
      end
    end
    W_FULL = 0;
  endtask

  task automatic test_timeout();
    int pulses;
    do_reset();
    pulses = 0;
    EN_MASK = 2'b11; REQ_VALID = 2'b11; REQ_LAST = 2'b10; d0 = 8'h5A; d1 = 8'h6B;
    for (int c = 0; c < 19; c++) begin
      @(negedge CLK);
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL tmo_model c%0d: got %h want %h", c, obs, exp_v); end
      if (TMO_ERR === 1'b1) pulses++;
      if (c >= 2 && c <= 17) begin
        checks++;
        if (TMO_ERR !== (c == 17))
          begin errors++; $display("FAIL tmo_pulse c%0d: got %b want %b", c, TMO_ERR, c == 17); end
      end
      if (c == 18) begin
        checks++;
        if (GRANT !== 2'b10) begin errors++; $display("FAIL tmo_regrant: got %b want 10", GRANT); end
      end
      @(posedge CLK); #1;
      if (c == 1) REQ_VALID[0] = 1'b0;
    end
    checks++;
    if (pulses != 1) begin errors++; $display("FAIL tmo_once: got %0d want 1", pulses); end
  endtask

  task automatic test_enmask();
    int beats;
    bit acc;
    do_reset();
    beats = 0;
    EN_MASK = 2'b10; REQ_VALID = 2'b11; REQ_LAST = 2'b01; d0 = 8'h0F; d1 = 8'h70;
    for (int c = 0; c < 8; c++) begin
      @(negedge CLK);
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL en_model c%0d: got %h want %h", c, obs, exp_v); end
      if (c == 1) begin
        checks++;
        if (GRANT !== 2'b10) begin errors++; $display("FAIL en_grant: got %b want 10", GRANT); end
      end
      acc = REQ_READY[1] && REQ_VALID[1];
      if (W_INC && GRANT === 2'b10) beats++;
      @(posedge CLK); #1;
      if (acc) begin
        EN_MASK[1] = 1'b0;
        if (beats >= 3) REQ_VALID[1] = 1'b0;
        else begin d1 = 8'h70 + 8'(beats); REQ_LAST[1] = (beats == 2); end
      end
    end
    checks++;
    if (beats != 3) begin errors++; $display("FAIL en_frame_done: got %0d beats want 3", beats); end
    EN_MASK = 2'b11;
  endtask

  task automatic test_reset_midframe();
    do_reset();
    EN_MASK = 2'b11; REQ_VALID = 2'b10; REQ_LAST = 2'b00; d0 = 8'h21; d1 = 8'h42;
    for (int c = 0; c < 6; c++) begin
      if (c == 3) begin RST = 1; REQ_VALID = 2'b11; REQ_LAST = 2'b11; end
      if (c == 4) RST = 0;
      @(negedge CLK);
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL rstmid_model c%0d: got %h want %h", c, obs, exp_v); end
      if (c == 4) begin
        checks++;
        if ({GRANT, BUSY, W_INC} !== 4'b0000)
          begin errors++; $display("FAIL rstmid_clear: got %b want 0000", {GRANT, BUSY, W_INC}); end
      end
      if (c == 5) begin
        checks++;
        if (GRANT !== 2'b01) begin errors++; $display("FAIL rstmid_first: got %b want 01", GRANT); end
      end
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 800; c++) begin
      RST = ($urandom_range(0, 199) == 0);
      EN_MASK = ($urandom_range(0, 3) == 0) ? N'($urandom) : 2'b11;
      W_FULL = ($urandom_range(0, 4) == 0);
      d0 = DW'($urandom); d1 = DW'($urandom);
      if ((c / 100) % 2 == 1) begin
        // sparse traffic with no frame ends, so stalls trip the watchdog
        REQ_VALID = ($urandom_range(0, 29) == 0) ? 2'b11 : 2'b00;
        REQ_LAST = '0;
        W_FULL = 0;
      end else begin
        REQ_VALID = N'($urandom);
        REQ_LAST = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
      end
      @(negedge CLK);
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL rand_model c%0d: got %h want %h", c, obs, exp_v); end
      @(posedge CLK); #1;
    end
    RST = 0;
  endtask

  initial begin
    test_reset();
    test_alternate();
    test_multibeat();
    test_full();
    test_timeout();
    test_enmask();
    test_reset_midframe();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Shares the single write port of the dual-clock FIFO between N_REQ requesters in the write-clock domain, e.g. register-file read data and ALU results. It arbitrates round-robin at frame granularity and locks the grant until the frame's LAST beat is written. It drives the FIFO write increment and data, and respects the FIFO full flag. A mid-frame watchdog frees the port if the granted requester stalls.

Parameters:
N_REQ, 2, number of requesters (2..8)
DATA_WIDTH, 8, FIFO write data width
TIMEOUT, 16, max consecutive idle cycles inside a locked frame before forced release (>=2)

Ports:
CLK  input  1  write-domain clock
RST  input  1  synchronous reset, active-high
EN_MASK  input  N_REQ  per-requester arbitration enable
REQ_VALID  input  N_REQ  requester has a beat
REQ_DATA  input  N_REQ*DATA_WIDTH  beat data, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
REQ_LAST  input  N_REQ  beat is the final beat of its frame
REQ_READY  output  N_REQ  beat accepted this cycle when VALID&READY
W_FULL  input  1  FIFO full flag (write domain)
W_INC  output  1  FIFO write strobe
WR_DATA  output  DATA_WIDTH  FIFO write data
GRANT  output  N_REQ  one-hot registered grant, 0 when idle
BUSY  output  1  grant held
TMO_ERR  output  1  one-cycle pulse on watchdog release

Behaviour:
- Clock and reset: one clock, CLK. RST is synchronous and active-high, sampled on the CLK rising edge.
- Reset state:
  - state IDLE; GRANT=0; BUSY=0; TMO_ERR=0.
  - Round-robin pointer rr_last=N_REQ-1, so port 0 has first priority.
  - Idle timer=0.
  - W_INC=0, REQ_READY=0.
  - WR_DATA=0 while GRANT=0.
- States: IDLE, LOCKED(g).
- Candidates: REQ_VALID & EN_MASK. The winner is the first candidate found scanning rr_last+1, rr_last+2, ... modulo N_REQ.
- IDLE:
  - No write activity.
  - If any candidate exists, register GRANT=onehot(winner) and go to LOCKED.
  - Arbitration latency is one cycle from VALID to GRANT.
- LOCKED(g), all outputs combinational from the registered GRANT:
  - REQ_READY[g] = !W_FULL; all other REQ_READY = 0.
  - W_INC = REQ_VALID[g] & !W_FULL.
  - WR_DATA = REQ_DATA[g].
  - Accepted beat = W_INC.
- End of frame: an accepted beat with REQ_LAST[g]=1 sets rr_last=g.
  - The same cycle re-arbitrates using rr_last=g as base.
  - If a winner exists, GRANT moves to it next cycle (back-to-back frames, no bubble); otherwise go to IDLE.
  - A single-beat frame is a beat with LAST=1.
- Full handling: while W_FULL=1, no beat is accepted, the timer does not count, and the grant is held. W_INC is never asserted with W_FULL=1.
- EN_MASK: sampled only at arbitration. Clearing EN_MASK[g] mid-frame does not abort frame g.
- Watchdog:
  - In LOCKED, timer increments each cycle with REQ_VALID[g]=0 and W_FULL=0.
  - Timer clears on any accepted beat.
  - When timer reaches TIMEOUT-1 and increments: pulse TMO_ERR for one cycle, set rr_last=g, clear timer, then re-arbitrate as at end of frame.
  - No beat is written that cycle.
- Width rules: rr_last and the timer are $clog2 sized. Pointer wrap is modulo N_REQ, non-power-of-2 N_REQ included.
- Reset mid-frame: immediate return to reset state on the next edge. Partial frames already written stay in the FIFO; the consumer resynchronises.
- GRANT and BUSY are registered; REQ_READY, W_INC and WR_DATA are combinational from state and inputs.

Decomposition:
- Shared package fifo_arb_pkg holds:
  - state encoding constants ST_IDLE and ST_LOCKED;
  - a clog2 helper;
  - the default TIMEOUT constant.
- One sub-module, rr_arb_pick: purely combinational masked round-robin picker.
  - Inputs: candidates[N_REQ], rr_last.
  - Outputs: found, winner index.
  - Used in both the IDLE and end-of-frame paths.

Test Plan:
- Reset, then REQ_VALID=2'b11, both LAST=1, EN_MASK=2'b11, W_FULL=0 -> GRANT=01 one cycle later; W_INC=1 with port 0 data; next cycle GRANT=10 with no bubble; ports alternate 0,1,0,1.
- Port 0 sends a 3-beat frame (AA,BB,CC, LAST on CC) while port 1 is valid throughout -> WR_DATA sequence AA,BB,CC, then port 1; REQ_READY[1]=0 during the frame.
- W_FULL=1 for 5 cycles mid-frame -> W_INC=0, REQ_READY[g]=0, grant held, no TMO_ERR; writing resumes the cycle W_FULL drops.
- Granted port drops VALID mid-frame for 16 cycles with TIMEOUT=16 -> TMO_ERR pulses exactly once on cycle 16; the other valid port is granted next cycle.
- EN_MASK=2'b10 with both valid -> only port 1 is granted. Clearing EN_MASK[1] mid-frame -> the frame still completes.
- RST asserted mid-frame -> next edge gives GRANT=0, BUSY=0, W_INC=0; the first arbitration after reset picks port 0.
